fifo_packet_source: RTL and testbench

Write-side packet transmitter for the asynchronous FIFO, running entirely in the wr_clk domain. On a start pulse it frames a packet as header, length, payload and checksum words, and pushes them into the FIFO write port. Writes obey the FIFO's wr_full back-pressure, so no word is dropped or duplicated. It replaces the free-running ROM source with a controlled, self-checking stream that the read-side consumer can validate.

---
 rtl/fifo_packet_source_if.sv | 23 ++
 rtl/fifo_packet_source.sv | 115 +++++++++++
 tb/tb_fifo_packet_source.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_packet_source_if.sv
// Write-port bundle between the packet source and the FIFO write side.
// The master modport is the packet source; the slave modport is whatever sits on the other side.
interface fifo_packet_source_if;
    logic        start;
    logic [7:0]  pkt_len;
    logic [7:0]  seed;
    logic        wr_full;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        busy;
    logic        done;
    logic [15:0] pkt_count;

    modport master (
        input  start, pkt_len, seed, wr_full,
        output wr_en, wr_data, busy, done, pkt_count
    );

    modport slave (
        output start, pkt_len, seed, wr_full,
        input  wr_en, wr_data, busy, done, pkt_count
    );
endinterface

// File: rtl/fifo_packet_source.sv
// Frames header/length/payload/checksum packets into the async FIFO write port.
// Every word waits for wr_full to clear, so a stalled FIFO only stretches the packet.
module fifo_packet_source #(
    parameter int         WIDTH  = 8,
    parameter logic [7:0] HEADER = 8'hA5
) (
    input  logic                 wr_clk,
    input  logic                 reset,
    fifo_packet_source_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        LEN,
        PAY,
        CSUM,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] len_q;
    logic [WIDTH-1:0] seed_q;
    logic [WIDTH-1:0] idx;
    logic [WIDTH-1:0] csum;
    logic [15:0]      pkt_count;
    logic             busy;
    logic             done;
    logic             emitting;
    logic             wr_en;
    logic [WIDTH-1:0] pay_word;
    logic [WIDTH-1:0] wr_data;

    // wr_en must react to wr_full in the same cycle, so it is decoded straight from state.
    always_comb begin
        emitting = (state == HDR) || (state == LEN) || (state == PAY) || (state == CSUM);
        wr_en    = emitting && !bus.wr_full;
        pay_word = seed_q + idx;
        wr_data  = '0;
        case (state)
            HDR:     wr_data = HEADER;
            LEN:     wr_data = len_q;
            PAY:     wr_data = pay_word;
            CSUM:    wr_data = csum;
            default: wr_data = '0;
        endcase
    end

    always_ff @(posedge wr_clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            len_q     <= '0;
            seed_q    <= '0;
            idx       <= '0;
            csum      <= '0;
            pkt_count <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        len_q  <= bus.pkt_len;
                        seed_q <= bus.seed;
                        idx    <= '0;
                        busy   <= 1'b1;
                        state  <= HDR;
                    end
                end
                HDR: begin
                    if (wr_en) begin
                        state <= LEN;
                    end
                end
                LEN: begin
                    if (wr_en) begin
                        csum  <= len_q;
                        state <= (len_q != '0) ? PAY : CSUM;
                    end
                end
                PAY: begin
                    if (wr_en) begin
                        csum <= csum + pay_word;
                        idx  <= idx + 1'b1;
                        if (idx == WIDTH'(len_q - 1'b1)) begin
                            state <= CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (wr_en) begin
                        pkt_count <= pkt_count + 16'd1;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.wr_en     = wr_en;
    assign bus.wr_data   = wr_data;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.pkt_count = pkt_count;

endmodule

// File: tb/tb_fifo_packet_source.sv
// Directed bench for fifo_packet_source: packet framing, back-pressure, wrap, ignored starts, reset abort.
module tb_fifo_packet_source;

    logic wr_clk;
    logic reset;

    fifo_packet_source_if bus ();

    fifo_packet_source dut (
        .wr_clk (wr_clk),
        .reset  (reset),
        .bus    (bus)
    );

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0] words [0:399];
    int         wcyc  [0:399];
    int         nwords;
    int         done_cyc;
    bit         busy_gap;
    logic       trace_en   [0:399];
    logic [7:0] trace_data [0:399];

    // Accepts a start at the next edge (edge 0) and returns 1ns into cycle 1; the
    // inputs are then scrambled so only the latched copies can matter.
    task automatic launch(input logic [7:0] len, input logic [7:0] sd);
        bus.pkt_len = len;
        bus.seed    = sd;
        bus.start   = 1'b1;
        @(posedge wr_clk);
        #1;
        bus.start   = 1'b0;
        bus.pkt_len = ~len;
        bus.seed    = sd ^ 8'h5A;
    endtask

    // Records one packet from cycle 1 until done, then steps into cycle done+1.
    task automatic capture(input int max_cycles, input int stall_from, input int stall_n,
                           input int pulse_a, input int pulse_b);
        nwords   = 0;
        done_cyc = -1;
        busy_gap = 1'b0;
        for (int cyc = 1; cyc <= max_cycles; cyc++) begin
            bus.wr_full = (cyc >= stall_from) && (cyc < stall_from + stall_n);
            bus.start   = (cyc == pulse_a) || (cyc == pulse_b);
            #1;
            trace_en[cyc]   = bus.wr_en;
            trace_data[cyc] = bus.wr_data;
            if (bus.wr_en) begin
                words[nwords] = bus.wr_data;
                wcyc[nwords]  = cyc;
                nwords++;
            end
            if (!bus.busy) busy_gap = 1'b1;
            if (bus.done) done_cyc = cyc;
            @(posedge wr_clk);
            #1;
            bus.start   = 1'b0;
            bus.wr_full = 1'b0;
            if (done_cyc != -1) break;
        end
        #1;
    endtask

    task automatic test_reset();
        bus.start   = 1'b0;
        bus.pkt_len = 8'd0;
        bus.seed    = 8'd0;
        bus.wr_full = 1'b0;
        reset       = 1'b1;
        repeat (2) @(posedge wr_clk);
        #1;
        checks++;
        if (bus.wr_en !== 1'b0 || bus.wr_data !== 8'h00 || bus.busy !== 1'b0 ||
            bus.done !== 1'b0 || bus.pkt_count !== 16'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got en=%b data=%h busy=%b done=%b cnt=%0d, want 0 0 0 0 0",
                     bus.wr_en, bus.wr_data, bus.busy, bus.done, bus.pkt_count);
        end
        reset = 1'b0;
        @(posedge wr_clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.wr_en !== 1'b0) begin
            failures++;
            $display("[TB] FAIL idle_after_reset: got busy=%b en=%b, want 0 0", bus.busy, bus.wr_en);
        end
    endtask

    task automatic test_basic();
        logic [7:0] exp [0:6] = '{8'hA5, 8'h04, 8'h10, 8'h11, 8'h12, 8'h13, 8'h4A};
        launch(8'd4, 8'h10);
        capture(40, 0, 0, 0, 0);
        checks++;
        if (nwords != 7) begin
            failures++;
            $display("[TB] FAIL basic_count: got %0d words, want 7", nwords);
        end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (words[i] !== exp[i] || wcyc[i] != i + 1) begin
                failures++;
                $display("[TB] FAIL basic_word%0d: got %h at cycle %0d, want %h at cycle %0d",
                         i, words[i], wcyc[i], exp[i], i + 1);
            end
        end
        checks++;
        if (done_cyc != 8) begin
            failures++;
            $display("[TB] FAIL basic_done_cycle: got %0d, want 8", done_cyc);
        end
        checks++;
        if (bus.pkt_count !== 16'd1 || bus.done !== 1'b0 || bus.busy !== 1'b0 || busy_gap) begin
            failures++;
            $display("[TB] FAIL basic_after: got cnt=%0d done=%b busy=%b gap=%b, want 1 0 0 0",
                     bus.pkt_count, bus.done, bus.busy, busy_gap);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp [0:6] = '{8'hA5, 8'h04, 8'h10, 8'h11, 8'h12, 8'h13, 8'h4A};
        launch(8'd4, 8'h10);
        capture(40, 4, 3, 0, 0);
        for (int c = 4; c <= 6; c++) begin
            checks++;
            if (trace_en[c] !== 1'b0 || trace_data[c] !== 8'h11) begin
                failures++;
                $display("[TB] FAIL stall_cycle%0d: got en=%b data=%h, want en=0 data=11",
                         c, trace_en[c], trace_data[c]);
            end
        end
        checks++;
        if (nwords != 7) begin
            failures++;
            $display("[TB] FAIL stall_count: got %0d words, want 7", nwords);
        end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (words[i] !== exp[i]) begin
                failures++;
                $display("[TB] FAIL stall_word%0d: got %h, want %h", i, words[i], exp[i]);
            end
        end
        checks++;
        if (done_cyc != 11 || bus.pkt_count !== 16'd2) begin
            failures++;
            $display("[TB] FAIL stall_done: got cycle %0d cnt %0d, want cycle 11 cnt 2",
                     done_cyc, bus.pkt_count);
        end
    endtask

    task automatic test_zero_length();
        logic [7:0] exp [0:2] = '{8'hA5, 8'h00, 8'h00};
        launch(8'd0, 8'h55);
        capture(20, 0, 0, 0, 0);
        checks++;
        if (nwords != 3) begin
            failures++;
            $display("[TB] FAIL zero_count: got %0d words, want 3", nwords);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (words[i] !== exp[i] || wcyc[i] != i + 1) begin
                failures++;
                $display("[TB] FAIL zero_word%0d: got %h at cycle %0d, want %h at cycle %0d",
                         i, words[i], wcyc[i], exp[i], i + 1);
            end
        end
        checks++;
        if (done_cyc != 4 || bus.pkt_count !== 16'd3) begin
            failures++;
            $display("[TB] FAIL zero_done: got cycle %0d cnt %0d, want cycle 4 cnt 3", done_cyc, bus.pkt_count);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp [0:5] = '{8'hA5, 8'h03, 8'hFE, 8'hFF, 8'h00, 8'h00};
        launch(8'd3, 8'hFE);
        capture(20, 0, 0, 0, 0);
        checks++;
        if (nwords != 6) begin
            failures++;
            $display("[TB] FAIL wrap_count: got %0d words, want 6", nwords);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (words[i] !== exp[i]) begin
                failures++;
                $display("[TB] FAIL wrap_word%0d: got %h, want %h", i, words[i], exp[i]);
            end
        end
        checks++;
        if (done_cyc != 7 || bus.pkt_count !== 16'd4) begin
            failures++;
            $display("[TB] FAIL wrap_done: got cycle %0d cnt %0d, want cycle 7 cnt 4", done_cyc, bus.pkt_count);
        end
    endtask

    task automatic test_ignored_start();
        logic [7:0] exp [0:4] = '{8'hA5, 8'h02, 8'h40, 8'h41, 8'h83};
        launch(8'd4, 8'h10);
        // Pulse in PAY (cycle 4) and in DONE (cycle 8); both must be dropped.
        capture(40, 0, 0, 4, 8);
        checks++;
        if (nwords != 7 || done_cyc != 8 || busy_gap) begin
            failures++;
            $display("[TB] FAIL ignore_first: got words=%0d done=%0d gap=%b, want 7 8 0",
                     nwords, done_cyc, busy_gap);
        end
        checks++;
        if (bus.wr_en !== 1'b0 || bus.busy !== 1'b0 || bus.pkt_count !== 16'd5) begin
            failures++;
            $display("[TB] FAIL ignore_idle: got en=%b busy=%b cnt=%0d, want 0 0 5",
                     bus.wr_en, bus.busy, bus.pkt_count);
        end
        launch(8'd2, 8'h40);
        capture(20, 0, 0, 0, 0);
        checks++;
        if (nwords != 5 || done_cyc != 6) begin
            failures++;
            $display("[TB] FAIL ignore_next: got words=%0d done=%0d, want 5 6", nwords, done_cyc);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (words[i] !== exp[i]) begin
                failures++;
                $display("[TB] FAIL ignore_next_word%0d: got %h, want %h", i, words[i], exp[i]);
            end
        end
    endtask

    task automatic test_reset_midpacket();
        logic [7:0] exp [0:4] = '{8'hA5, 8'h02, 8'h30, 8'h31, 8'h63};
        launch(8'd10, 8'h20);
        repeat (4) @(posedge wr_clk);
        #1;
        checks++;
        if (bus.wr_en !== 1'b1 || bus.wr_data !== 8'h22) begin
            failures++;
            $display("[TB] FAIL abort_inpay: got en=%b data=%h, want 1 22", bus.wr_en, bus.wr_data);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (bus.wr_en !== 1'b0 || bus.busy !== 1'b0 || bus.pkt_count !== 16'd0 ||
            bus.wr_data !== 8'h00 || bus.done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_reset: got en=%b busy=%b cnt=%0d data=%h done=%b, want 0 0 0 00 0",
                     bus.wr_en, bus.busy, bus.pkt_count, bus.wr_data, bus.done);
        end
        @(posedge wr_clk);
        #1;
        reset = 1'b0;
        @(posedge wr_clk);
        #1;
        launch(8'd2, 8'h30);
        capture(20, 0, 0, 0, 0);
        checks++;
        if (nwords != 5 || done_cyc != 6 || bus.pkt_count !== 16'd1) begin
            failures++;
            $display("[TB] FAIL abort_recover: got words=%0d done=%0d cnt=%0d, want 5 6 1",
                     nwords, done_cyc, bus.pkt_count);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (words[i] !== exp[i]) begin
                failures++;
                $display("[TB] FAIL abort_word%0d: got %h, want %h", i, words[i], exp[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_length();
        test_wrap();
        test_ignored_start();
        test_reset_midpacket();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
